// File: rtl/kvaz_multi_mapper_if.sv
// Bus bundle for kvaz_multi_mapper.
// Purpose : groups the CPU-side decode/strobe signals and the mapper outputs
//           so the mapper and its driver share one connection point.
// Signals : clke        bus-cycle clock enable
//           address     CPU address
//           select      one-hot control-register write strobe, bit i = disk i
//           data_in     CPU data for control register writes
//           stack       current access is a stack access
//           memwr/memrd memory write/read cycle active
//           bigram_addr SRAM page (0 = main RAM)
//           conflict    sticky multi-disk claim flag
//           debug       committed control registers, disk 0 in the low byte
// Modports: master drives the bus and observes results; slave is the mapper.
interface kvaz_multi_mapper_if #(
  parameter int NDISK = 2,
  parameter int OUT_W = 4
);
  logic                   clke;
  logic [15:0]            address;
  logic [NDISK-1:0]       select;
  logic [7:0]             data_in;
  logic                   stack;
  logic                   memwr;
  logic                   memrd;
  logic [OUT_W-1:0]       bigram_addr;
  logic                   conflict;
  logic [8*NDISK-1:0]     debug;

  modport master (
    output clke, address, select, data_in, stack, memwr, memrd,
    input  bigram_addr, conflict, debug
  );

  modport slave (
    input  clke, address, select, data_in, stack, memwr, memrd,
    output bigram_addr, conflict, debug
  );
endinterface

// File: rtl/kvaz_multi_mapper.sv
// kvaz_multi_mapper
// Purpose : maps NDISK Vector-06C RAM disks into the SRAM page space.
//           Page 0 is main RAM; disk i page p maps to 1 + 4*i + p.
//           Each disk has a control register whose writes are deferred
//           while a memory cycle is in progress.
// Ports   : clk      system clock
//           reset_n  asynchronous active-low reset
//           bus      kvaz_multi_mapper_if slave (bus inputs, page/conflict/debug)
module kvaz_multi_mapper #(
  parameter int         NDISK   = 2,
  parameter int         OUT_W   = 4,
  parameter logic [3:0] WIN_LO  = 4'hA,
  parameter logic [3:0] WIN_HI  = 4'hD,
  parameter bit         REG_OUT = 1'b0
) (
  input logic                 clk,
  input logic                 reset_n,
  kvaz_multi_mapper_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [NDISK-1:0][7:0] ctrl_q;
  logic [NDISK-1:0][7:0] pend_val_q;
  logic [NDISK-1:0]      state_q;
  logic [NDISK-1:0]      commit;
  logic [NDISK-1:0]      commit_msb;
  logic [NDISK-1:0]      stk_claim;
  logic [NDISK-1:0]      ram_claim;
  logic [NDISK-1:0]      any_claim;
  logic                  mem_cyc;
  logic                  in_window;
  logic                  multi_claim;
  logic                  conflict_clr;
  logic                  conflict_q;
  logic [OUT_W-1:0]      stk_page;
  logic [OUT_W-1:0]      ram_page;
  logic                  stk_hit;
  logic                  ram_hit;
  logic [OUT_W-1:0]      page_d;

  assign mem_cyc   = bus.memrd | bus.memwr;
  assign in_window = (bus.address[15:12] >= WIN_LO) && (bus.address[15:12] <= WIN_HI);

  genvar gi;
  generate
    for (gi = 0; gi < NDISK; gi++) begin : g_disk
      // A write reaches ctrl either directly from an idle bus or from the
      // pending slot once the bus goes idle with no newer write arriving.
      assign commit[gi] = bus.clke & ~mem_cyc &
                          ((state_q[gi] == ST_IDLE) ? bus.select[gi] : ~bus.select[gi]);
      assign commit_msb[gi] = (state_q[gi] == ST_IDLE) ? bus.data_in[7] : pend_val_q[gi][7];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ctrl_q[gi]     <= 8'h00;
          pend_val_q[gi] <= 8'h00;
          state_q[gi]    <= ST_IDLE;
        end else if (bus.clke) begin
          case (state_q[gi])
            ST_IDLE: begin
              if (bus.select[gi]) begin
                if (mem_cyc) begin
                  pend_val_q[gi] <= bus.data_in;
                  state_q[gi]    <= ST_PEND;
                end else begin
                  ctrl_q[gi] <= bus.data_in;
                end
              end
            end
            default: begin
              if (bus.select[gi]) begin
                pend_val_q[gi] <= bus.data_in;
              end else if (!mem_cyc) begin
                ctrl_q[gi]  <= pend_val_q[gi];
                state_q[gi] <= ST_IDLE;
              end
            end
          endcase
        end
      end

      assign stk_claim[gi] = ctrl_q[gi][4] & bus.stack & mem_cyc;
      assign ram_claim[gi] = ctrl_q[gi][5] & in_window & mem_cyc;
      assign any_claim[gi] = stk_claim[gi] | ram_claim[gi];
    end
  endgenerate

  // Descending scan so the lowest-numbered claimant is written last and wins.
  always_comb begin
    stk_page = '0;
    ram_page = '0;
    stk_hit  = 1'b0;
    ram_hit  = 1'b0;
    for (int i = NDISK - 1; i >= 0; i--) begin
      if (stk_claim[i]) begin
        stk_hit  = 1'b1;
        stk_page = OUT_W'(1 + 4 * i) + OUT_W'(ctrl_q[i][3:2]);
      end
      if (ram_claim[i]) begin
        ram_hit  = 1'b1;
        ram_page = OUT_W'(1 + 4 * i) + OUT_W'(ctrl_q[i][1:0]);
      end
    end
    if (stk_hit) begin
      page_d = stk_page;
    end else if (ram_hit) begin
      page_d = ram_page;
    end else begin
      page_d = '0;
    end
  end

  // More than one bit set means at least two disks claimed this access.
  assign multi_claim  = (any_claim & (any_claim - 1'b1)) != '0;
  assign conflict_clr = |(commit & commit_msb);

  // Not clke-gated: a claim collision is recorded on every edge; set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= multi_claim | (conflict_q & ~conflict_clr);
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [OUT_W-1:0] bigram_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          bigram_q <= '0;
        end else begin
          bigram_q <= page_d;
        end
      end
      assign bus.bigram_addr = bigram_q;
    end else begin : g_comb_out
      assign bus.bigram_addr = page_d;
    end
  endgenerate

  assign bus.conflict = conflict_q;
  assign bus.debug    = ctrl_q;

endmodule

// File: tb/tb_kvaz_multi_mapper.sv
// Testbench for kvaz_multi_mapper: two instances (combinational and registered
// output) share one stimulus stream and are compared against a reference model.
module tb_kvaz_multi_mapper;
  localparam int NDISK = 2;
  localparam int OUT_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic             clke;
  logic [15:0]      address;
  logic [NDISK-1:0] select;
  logic [7:0]       data_in;
  logic             stack, memwr, memrd;

  kvaz_multi_mapper_if #(.NDISK(NDISK), .OUT_W(OUT_W)) bus0 ();
  kvaz_multi_mapper_if #(.NDISK(NDISK), .OUT_W(OUT_W)) bus1 ();

  assign bus0.clke = clke;    assign bus1.clke = clke;
  assign bus0.address = address; assign bus1.address = address;
  assign bus0.select = select;   assign bus1.select = select;
  assign bus0.data_in = data_in; assign bus1.data_in = data_in;
  assign bus0.stack = stack;     assign bus1.stack = stack;
  assign bus0.memwr = memwr;     assign bus1.memwr = memwr;
  assign bus0.memrd = memrd;     assign bus1.memrd = memrd;

  kvaz_multi_mapper #(.NDISK(NDISK), .OUT_W(OUT_W), .WIN_LO(4'hA), .WIN_HI(4'hD), .REG_OUT(1'b0))
    dut_comb (.clk(clk), .reset_n(reset_n), .bus(bus0));
  kvaz_multi_mapper #(.NDISK(NDISK), .OUT_W(OUT_W), .WIN_LO(4'hA), .WIN_HI(4'hD), .REG_OUT(1'b1))
    dut_reg (.clk(clk), .reset_n(reset_n), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: disk registers, pending slots, sticky flag, delayed page.
  logic [7:0] m_ctrl [NDISK];
  logic [7:0] m_pend [NDISK];
  bit         m_inpend [NDISK];
  bit         m_conf;
  int         m_regpage;

  function automatic bit m_mem();
    return memrd || memwr;
  endfunction

  function automatic bit m_win();
    return (address[15:12] >= 4'hA) && (address[15:12] <= 4'hD);
  endfunction

  // Page chosen for the current access: lowest stacked disk, else lowest window disk.
  function automatic int m_page();
    if (!m_mem()) return 0;
    if (stack)
      for (int i = 0; i < NDISK; i++)
        if (m_ctrl[i][4]) return 1 + 4 * i + int'(m_ctrl[i][3:2]);
    if (m_win())
      for (int i = 0; i < NDISK; i++)
        if (m_ctrl[i][5]) return 1 + 4 * i + int'(m_ctrl[i][1:0]);
    return 0;
  endfunction

  function automatic int m_claims();
    int n = 0;
    if (!m_mem()) return 0;
    for (int i = 0; i < NDISK; i++)
      if ((m_ctrl[i][4] && stack) || (m_ctrl[i][5] && m_win())) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDISK; i++) begin
      m_ctrl[i] = 8'h00; m_pend[i] = 8'h00; m_inpend[i] = 0;
    end
    m_conf = 0;
    m_regpage = 0;
  endtask

  task automatic model_edge();
    int  pg = m_page();
    int  nc = m_claims();
    bit  clr = 0;
    if (clke) begin
      for (int i = 0; i < NDISK; i++) begin
        if (select[i]) begin
          if (m_inpend[i] || m_mem()) begin
            m_pend[i] = data_in;
            m_inpend[i] = 1;
          end else begin
            m_ctrl[i] = data_in;
            clr |= data_in[7];
          end
        end else if (m_inpend[i] && !m_mem()) begin
          m_ctrl[i] = m_pend[i];
          m_inpend[i] = 0;
          clr |= m_pend[i][7];
        end
      end
    end
    if (nc > 1) m_conf = 1;
    else if (clr) m_conf = 0;
    m_regpage = pg;
  endtask

  task automatic drive(input bit ce, input logic [15:0] a, input logic [NDISK-1:0] sel,
                       input logic [7:0] d, input bit stk, input bit wr, input bit rd);
    clke = ce; address = a; select = sel; data_in = d; stack = stk; memwr = wr; memrd = rd;
  endtask

  task automatic check_outputs();
    check("page_comb", 32'(bus0.bigram_addr), 32'(m_page()));
    check("page_reg", 32'(bus1.bigram_addr), 32'(m_regpage));
    check("conflict", 32'(bus0.conflict), 32'(m_conf));
    check("conflict_r", 32'(bus1.conflict), 32'(m_conf));
    check("debug", 32'(bus0.debug), {16'h0, m_ctrl[1], m_ctrl[0]});
  endtask

  // Called just after a negedge with inputs driven: check, take one edge, return at negedge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    $display("step a=%h sel=%b d=%h ce=%0d stk=%0d wr=%0d rd=%0d -> page=%0d conf=%0d dbg=%h",
             address, select, data_in, clke, stack, memwr, memrd,
             bus0.bigram_addr, bus0.conflict, bus0.debug);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(1, 16'h0000, '0, 8'h00, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    // T1: reset state
    check("t1_page", 32'(bus0.bigram_addr), 0);
    check("t1_page_r", 32'(bus1.bigram_addr), 0);
    check("t1_conf", 32'(bus0.conflict), 0);
    check("t1_debug", 32'(bus0.debug), 0);
    reset_n = 1'b1;
    step();

    // T2: window mapping, and its one-clock lag on the registered instance
    drive(1, 16'h0000, 2'b01, 8'h22, 0, 0, 0); step();
    drive(1, 16'hA123, 2'b00, 8'h00, 0, 0, 1); #1;
    check("t2_win", 32'(bus0.bigram_addr), 3);
    step();
    check("t6_lag", 32'(bus1.bigram_addr), 3);
    drive(1, 16'h9FFF, 2'b00, 8'h00, 0, 0, 1); #1;
    check("t2_outside", 32'(bus0.bigram_addr), 0);
    check("t6_lag_hold", 32'(bus1.bigram_addr), 3);
    step();
    check("t6_lag_zero", 32'(bus1.bigram_addr), 0);

    // T3: stack beats window
    drive(1, 16'h0000, 2'b10, 8'h1C, 0, 0, 0); step();
    drive(1, 16'h0000, 2'b01, 8'h20, 0, 0, 0); step();
    drive(1, 16'hB000, 2'b00, 8'h00, 1, 1, 0); #1;
    check("t3_stack", 32'(bus0.bigram_addr), 8);
    step();

    // T4: deferred write, last one wins, commit waits for clke with idle bus
    drive(1, 16'h0000, 2'b01, 8'h22, 0, 0, 0); step();
    drive(1, 16'h1234, 2'b01, 8'h21, 0, 0, 1); step();
    check("t4_held", 32'(bus0.debug[7:0]), 32'h22);
    drive(1, 16'h1234, 2'b01, 8'h25, 0, 0, 1); step();
    drive(0, 16'h0000, 2'b00, 8'h00, 0, 0, 0); step();
    check("t4_noclke", 32'(bus0.debug[7:0]), 32'h22);
    drive(1, 16'h0000, 2'b00, 8'h00, 0, 0, 0); step();
    check("t4_commit", 32'(bus0.debug[7:0]), 32'h25);

    // T5: two window claims -> lowest disk, sticky conflict, cleared by bit7 write
    drive(1, 16'h0000, 2'b01, 8'hA0, 0, 0, 0); step();
    check("t5_clear0", 32'(bus0.conflict), 0);
    drive(1, 16'h0000, 2'b01, 8'h20, 0, 0, 0); step();
    drive(1, 16'h0000, 2'b10, 8'h21, 0, 0, 0); step();
    drive(1, 16'hC000, 2'b00, 8'h00, 0, 0, 1); #1;
    check("t5_page", 32'(bus0.bigram_addr), 1);
    step();
    check("t5_conf", 32'(bus0.conflict), 1);
    drive(1, 16'h0000, 2'b00, 8'h00, 0, 0, 0); step();
    check("t5_sticky", 32'(bus0.conflict), 1);
    drive(1, 16'h0000, 2'b01, 8'hA0, 0, 0, 0); step();
    check("t5_cleared", 32'(bus0.conflict), 0);

    // T6: async reset while a write is pending
    drive(1, 16'h5000, 2'b10, 8'h3F, 0, 1, 0); step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_debug", 32'(bus0.debug), 0);
    check("t6_rst_page_r", 32'(bus1.bigram_addr), 0);
    check("t6_rst_conf", 32'(bus0.conflict), 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 16'h0000, 2'b00, 8'h00, 0, 0, 0); step();
    check("t6_lost", 32'(bus0.debug), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      logic [7:0]  d;
      bit ce, stk, wr, rd;
      logic [NDISK-1:0] sel;
      a   = 16'($urandom);
      d   = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7] = 1'b0;
      ce  = ($urandom_range(0, 3) != 0);
      stk = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      sel = ($urandom_range(0, 2) == 0) ? NDISK'($urandom) : '0;
      drive(ce, a, sel, d, stk, wr, rd);
      step();
    end

    drive(1, 16'h0000, '0, 8'h00, 0, 0, 0);
    #1;
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
